user_clk_switch_ctrl: RTL and testbench
=======================================

USER_CLK_SWITCH_CTRL -- requirements
Module: user_clk_switch_ctrl

Interface
REQ-001 Parameter WDOG_CYCLES, default 64: aclk cycles without a heartbeat before a source clock is declared dead (range 4..4095).
REQ-002 Parameter SETTLE_CYCLES, default 16: aclk cycles held busy after `selection` changes (range 1..255).
REQ-003 aclk  input  1  free-running control clock; the only clock of this block; all ports synchronous to its rising edge.
REQ-004 areset  input  1  reset; synchronous, active-high.
REQ-005 clk1_alive_tgl  input  1  toggle driven from the aclk_in1 domain; asynchronous to aclk.
REQ-006 clk2_alive_tgl  input  1  toggle driven from the aclk_in2 domain; asynchronous to aclk.
REQ-007 req_valid  input  1  switch request strobe.
REQ-008 req_sel  input  1  requested source: 0 = aclk_in1, 1 = aclk_in2.
REQ-009 req_ready  output  1  request can be accepted this cycle.
REQ-010 req_ack  output  1  one-cycle pulse: request completed.
REQ-011 req_err  output  1  one-cycle pulse: request rejected because the target clock is dead.
REQ-012 selection  output  1  select line for the glitch-free BUFGCTRL mux: 0 = aclk_in1, 1 = aclk_in2.
REQ-013 busy  output  1  switch in progress.
REQ-014 clk1_ok, clk2_ok  output  1 each  source-clock health flags.
REQ-015 failover  output  1  one-cycle pulse: automatic switch started.

Function
REQ-016 Each alive toggle SHALL pass through a 3-flop synchronizer; stage2 XOR stage3 SHALL form a one-cycle heartbeat pulse.
REQ-017 Each clock SHALL have a watchdog counter of width clog2(WDOG_CYCLES+1): cleared to 0 on heartbeat, else incremented, saturating at WDOG_CYCLES.
REQ-018 clkN_ok SHALL be registered and equal (counter < WDOG_CYCLES).
REQ-019 FSM states: ON1 (selection=0), SW_TO2, ON2 (selection=1), SW_TO1; selection SHALL be a registered output equal to the target of the current state.
REQ-020 req_ready SHALL be 1 only in ON1/ON2 and only when no failover fires in that cycle.
REQ-021 Accept = req_valid & req_ready; req_valid while req_ready=0 SHALL be ignored, not queued.
REQ-022 Accepted req_sel equal to the current source: req_ack SHALL pulse the next cycle, with no state change.
REQ-023 Accepted req_sel whose target clkN_ok=0: req_err SHALL pulse the next cycle, with no state change.
REQ-024 Otherwise the FSM SHALL enter SW_TOx the next cycle, with selection toggled and busy=1 on that same cycle.
REQ-025 In SW_TOx, a settle counter SHALL run SETTLE_CYCLES cycles, then the FSM SHALL enter ONx and busy SHALL drop; req_ack SHALL pulse on the same cycle only if the switch was request-initiated.
REQ-026 Total latency from an accepted cross-switch request to req_ack SHALL be SETTLE_CYCLES+1 cycles.
REQ-027 A clock dying during SW_TOx SHALL NOT abort the switch; the health check is re-evaluated once the FSM reaches ON1/ON2.
REQ-028 At most one of req_ack, req_err and failover SHALL pulse in any cycle.

Reset
REQ-029 On areset=1 at a clock edge: FSM=ON1, selection=0, busy=0, req_ack=req_err=failover=0, settle counter=0, synchronizers=0.
REQ-030 On reset, watchdog counters SHALL load WDOG_CYCLES, so clk1_ok=clk2_ok=0 until the first heartbeat.
REQ-031 Reset asserted mid-switch SHALL force ON1/selection=0 at the next edge without completing the switch or pulsing req_ack.

Configuration
REQ-032 Macro USER_CLKSW_AUTO_FAILOVER_EN, when defined: in ON1/ON2 with the active clock ok=0 and the other ok=1, the FSM SHALL start a switch as in REQ-024, pulse failover for 1 cycle, and take priority over a same-cycle request.
REQ-033 When USER_CLKSW_AUTO_FAILOVER_EN is undefined: no automatic switching; failover SHALL be tied 0; REQ-020 reduces to state-only readiness.

Verification
REQ-034 Reset, then toggle both alive inputs every 8 aclk cycles -> clk1_ok=clk2_ok=1 within 4 cycles of the first toggle; selection=0.
REQ-035 Both ok, req_valid=1 with req_sel=1 -> next cycle selection=1 and busy=1; busy=0 and req_ack=1 at cycle 17 after acceptance (SETTLE_CYCLES=16).
REQ-036 Stop clk2_alive_tgl for 64 cycles, then request req_sel=1 -> clk2_ok=0, req_err pulses once, selection stays 0.
REQ-037 With USER_CLKSW_AUTO_FAILOVER_EN, on clock 2, stop clk2 toggles -> after WDOG_CYCLES+4 cycles failover pulses and selection=0; without the macro, selection stays 1 and failover=0.
REQ-038 Failover condition and req_valid in the same cycle -> failover wins, request ignored, no req_ack/req_err.
REQ-039 areset asserted 5 cycles into SW_TO2 -> next cycle selection=0, busy=0, no req_ack.

Source files
------------

// File: rtl/user_clk_switch_ctrl.sv
// user_clk_switch_ctrl
// Control FSM for a glitch-free two-source clock mux. Each source proves it
// is alive by toggling a heartbeat line. A watchdog per source turns that
// heartbeat into a health flag. A small FSM drives the mux select line and
// holds it steady for a settle window after every change.
// Optional feature macro: USER_CLKSW_AUTO_FAILOVER_EN. When it is defined,
// the controller moves off a dead active clock onto a healthy spare clock
// without being asked.
module user_clk_switch_ctrl #(
   parameter int WDOG_CYCLES   = 64,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic aclk,
   input  logic areset,
   input  logic clk1_alive_tgl,
   input  logic clk2_alive_tgl,
   input  logic req_valid,
   input  logic req_sel,
   output logic req_ready,
   output logic req_ack,
   output logic req_err,
   output logic selection,
   output logic busy,
   output logic clk1_ok,
   output logic clk2_ok,
   output logic failover
);

   localparam int              WD_W        = $clog2(WDOG_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX      = WD_W'(WDOG_CYCLES);
   localparam logic [WD_W-1:0] WD_ONE      = WD_W'(1);
   localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   localparam logic [1:0] ST_ON1    = 2'd0;
   localparam logic [1:0] ST_SW_TO2 = 2'd1;
   localparam logic [1:0] ST_ON2    = 2'd2;
   localparam logic [1:0] ST_SW_TO1 = 2'd3;

   logic [1:0]      w_tgl;
   logic [2:0]      r_sync   [2];
   logic [1:0]      w_hb;
   logic [WD_W-1:0] r_wd     [2];
   logic [WD_W-1:0] w_wd_nxt [2];
   logic [1:0]      r_ok;

   logic [1:0] r_state;
   logic [7:0] r_settle;
   logic       r_sel;
   logic       r_busy;
   logic       r_ack;
   logic       r_err;
   logic       r_from_req;
   logic       w_on;
   logic       w_oth_ok;
   logic       w_fo_fire;
   logic       w_accept;

   assign w_tgl = {clk2_alive_tgl, clk1_alive_tgl};

   // Bring the toggle inputs into aclk through three flops.
   // A change between stages two and three gives one heartbeat pulse.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < 2; i++) begin
         if (areset) begin
            r_sync[i] <= 3'b000;
         end else begin
            r_sync[i] <= {r_sync[i][1:0], w_tgl[i]};
         end
      end
   end

   // Next watchdog value. A heartbeat clears the count. Otherwise the count
   // climbs and then sticks at the timeout value.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_hb[i]     = r_sync[i][1] ^ r_sync[i][2];
         w_wd_nxt[i] = r_wd[i];
         if (w_hb[i]) begin
            w_wd_nxt[i] = '0;
         end else if (r_wd[i] < WD_MAX) begin
            w_wd_nxt[i] = r_wd[i] + WD_ONE;
         end
      end
   end

   // Watchdog counters and health flags. Reset loads the timeout value, so a
   // clock counts as dead until its first heartbeat. Each flag is computed
   // from the same next count, so it always matches the stored counter.
   always_ff @(posedge aclk) begin
      for (int i = 0; i < 2; i++) begin
         if (areset) begin
            r_wd[i] <= WD_MAX;
            r_ok[i] <= 1'b0;
         end else begin
            r_wd[i] <= w_wd_nxt[i];
            r_ok[i] <= (w_wd_nxt[i] < WD_MAX);
         end
      end
   end

   assign w_on     = (r_state == ST_ON1) || (r_state == ST_ON2);
   assign w_oth_ok = r_sel ? r_ok[0] : r_ok[1];

`ifdef USER_CLKSW_AUTO_FAILOVER_EN
   logic w_cur_ok;
   logic r_fo;

   assign w_cur_ok  = r_sel ? r_ok[1] : r_ok[0];
   assign w_fo_fire = w_on & ~w_cur_ok & w_oth_ok;

   // One-cycle failover pulse. It lines up with the cycle where the FSM
   // enters the switching state.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_fo <= 1'b0;
      end else begin
         r_fo <= w_fo_fire;
      end
   end

   assign failover = r_fo;
`else
   assign w_fo_fire = 1'b0;
   assign failover  = 1'b0;
`endif

   assign req_ready = w_on & ~w_fo_fire;
   assign w_accept  = req_valid & req_ready;

   // Switch FSM. In a steady state, an automatic failover beats a request
   // that arrives in the same cycle. Every switch flips the select line at
   // once and then waits out the settle window before it reports done.
   // A clock that dies during the window does not abort the switch.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_state    <= ST_ON1;
         r_sel      <= 1'b0;
         r_busy     <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_settle   <= 8'd0;
         r_from_req <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_ON1, ST_ON2: begin
               if (w_fo_fire) begin
                  r_state    <= r_sel ? ST_SW_TO1 : ST_SW_TO2;
                  r_sel      <= ~r_sel;
                  r_busy     <= 1'b1;
                  r_settle   <= 8'd0;
                  r_from_req <= 1'b0;
               end else if (w_accept) begin
                  if (req_sel == r_sel) begin
                     r_ack <= 1'b1;
                  end else if (!w_oth_ok) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state    <= r_sel ? ST_SW_TO1 : ST_SW_TO2;
                     r_sel      <= ~r_sel;
                     r_busy     <= 1'b1;
                     r_settle   <= 8'd0;
                     r_from_req <= 1'b1;
                  end
               end
            end
            default: begin
               if (r_settle == SETTLE_LAST) begin
                  r_state  <= r_sel ? ST_ON2 : ST_ON1;
                  r_busy   <= 1'b0;
                  r_ack    <= r_from_req;
                  r_settle <= 8'd0;
               end else begin
                  r_settle <= r_settle + 8'd1;
               end
            end
         endcase
      end
   end

   assign req_ack   = r_ack;
   assign req_err   = r_err;
   assign selection = r_sel;
   assign busy      = r_busy;
   assign clk1_ok   = r_ok[0];
   assign clk2_ok   = r_ok[1];

endmodule

// File: tb/tb_user_clk_switch_ctrl.sv
// tb_user_clk_switch_ctrl
// Bench for user_clk_switch_ctrl. It uses directed scenarios plus a random run.
// A behavioural model predicts every output. The model works from toggle
// timestamps and switch deadlines. USER_CLKSW_AUTO_FAILOVER_EN selects the
// expected behaviour when a clock dies.
`timescale 1ns/1ps
module tb_user_clk_switch_ctrl;

   localparam int WDOG   = 64;
   localparam int SETTLE = 16;
`ifdef USER_CLKSW_AUTO_FAILOVER_EN
   localparam bit FO_EN = 1'b1;
`else
   localparam bit FO_EN = 1'b0;
`endif

   logic aclk           = 1'b0;
   logic areset         = 1'b0;
   logic clk1_alive_tgl = 1'b0;
   logic clk2_alive_tgl = 1'b0;
   logic req_valid      = 1'b0;
   logic req_sel        = 1'b0;
   logic req_ready, req_ack, req_err, selection, busy, clk1_ok, clk2_ok, failover;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   int tq1[$];
   int tq2[$];
   bit auto1 = 1'b0, auto2 = 1'b0;
   int per1 = 8, per2 = 8, ph1 = 0, ph2 = 3;

   bit   mSel, mBusy, mAck, mErr, mFo, mFromReq, mOk1, mOk2, mReadyPre;
   int   mEnd;
   logic dutReadyPre;

   user_clk_switch_ctrl #(.WDOG_CYCLES(WDOG), .SETTLE_CYCLES(SETTLE)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .clk1_alive_tgl(clk1_alive_tgl),
      .clk2_alive_tgl(clk2_alive_tgl),
      .req_valid     (req_valid),
      .req_sel       (req_sel),
      .req_ready     (req_ready),
      .req_ack       (req_ack),
      .req_err       (req_err),
      .selection     (selection),
      .busy          (busy),
      .clk1_ok       (clk1_ok),
      .clk2_ok       (clk2_ok),
      .failover      (failover)
   );

   // Free-running control clock
   always #5 aclk = ~aclk;

   // A clock counts as healthy at edge e if its newest toggle that has
   // already crossed the synchronizer (driven at n <= e-3) is fewer than
   // WDOG edges old.
   function automatic bit okAt(input int q[$], input int e);
      int last;
      last = -1;
      foreach (q[i]) if (q[i] <= e - 3) last = q[i];
      return (last >= 0) && ((e - last - 3) < WDOG);
   endfunction

   // Drives the toggles and reset for one cycle.
   // Advances the clock and moves the model forward by one edge.
   task automatic applyStimulus(input bit rst);
      bit curOk, othOk, foNow;
      if (rst) begin
         clk1_alive_tgl = 1'b0;
         clk2_alive_tgl = 1'b0;
      end else begin
         if (auto1 && (cyc % per1) == ph1) begin
            clk1_alive_tgl = ~clk1_alive_tgl;
            tq1.push_back(cyc);
         end
         if (auto2 && (cyc % per2) == ph2) begin
            clk2_alive_tgl = ~clk2_alive_tgl;
            tq2.push_back(cyc);
         end
      end
      areset = rst;
      curOk = mSel ? mOk2 : mOk1;
      othOk = mSel ? mOk1 : mOk2;
      foNow = FO_EN && !mBusy && !curOk && othOk;
      mReadyPre   = !mBusy && !foNow;
      dutReadyPre = req_ready;
      @(posedge aclk);
      cyc++;
      mAck = 1'b0; mErr = 1'b0; mFo = 1'b0;
      if (rst) begin
         mSel = 1'b0; mBusy = 1'b0; mFromReq = 1'b0;
         tq1.delete(); tq2.delete();
      end else if (mBusy) begin
         if (cyc == mEnd) begin
            mBusy = 1'b0;
            mAck  = mFromReq;
         end
      end else if (foNow) begin
         mSel = !mSel; mBusy = 1'b1; mEnd = cyc + SETTLE; mFromReq = 1'b0; mFo = 1'b1;
      end else if (req_valid) begin
         if (req_sel == mSel) mAck = 1'b1;
         else if (!othOk) mErr = 1'b1;
         else begin
            mSel = !mSel; mBusy = 1'b1; mEnd = cyc + SETTLE; mFromReq = 1'b1;
         end
      end
      mOk1 = okAt(tq1, cyc);
      mOk2 = okAt(tq2, cyc);
      while (tq1.size() > 1 && tq1[1] <= cyc - 3) void'(tq1.pop_front());
      while (tq2.size() > 1 && tq2[1] <= cyc - 3) void'(tq2.pop_front());
      #1;
   endtask

   // Reset values of every output
   task automatic test_reset();
      auto1 = 1'b0; auto2 = 1'b0; req_valid = 1'b0;
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checks++; if (selection !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %b want 0", selection); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if ({req_ack, req_err, failover} !== 3'b000) begin errors++; $display("[TB] FAIL reset_pulses: got %b want 000", {req_ack, req_err, failover}); end
      checks++; if ({clk1_ok, clk2_ok} !== 2'b00) begin errors++; $display("[TB] FAIL reset_ok: got %b want 00", {clk1_ok, clk2_ok}); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", req_ready); end
   endtask

   // Heartbeats bring both health flags up within four cycles of the first toggle
   task automatic test_heartbeat();
      int first1, first2;
      first1 = -1; first2 = -1;
      auto1 = 1'b1; auto2 = 1'b1; per1 = 8; per2 = 8; ph1 = 0; ph2 = 3;
      for (int k = 0; k < 40; k++) begin
         applyStimulus(1'b0);
         if (first1 < 0 && tq1.size() > 0) first1 = tq1[0];
         if (first2 < 0 && tq2.size() > 0) first2 = tq2[0];
         checks++; if ({clk1_ok, clk2_ok} !== {mOk1, mOk2}) begin errors++; $display("[TB] FAIL hb_ok cyc=%0d: got %b want %b", cyc, {clk1_ok, clk2_ok}, {mOk1, mOk2}); end
         if (first1 >= 0 && cyc == first1 + 4) begin
            checks++; if (clk1_ok !== 1'b1) begin errors++; $display("[TB] FAIL hb_ok1_latency: got %b want 1", clk1_ok); end
         end
         if (first2 >= 0 && cyc == first2 + 4) begin
            checks++; if (clk2_ok !== 1'b1) begin errors++; $display("[TB] FAIL hb_ok2_latency: got %b want 1", clk2_ok); end
         end
      end
      checks++; if (selection !== 1'b0) begin errors++; $display("[TB] FAIL hb_sel: got %b want 0", selection); end
   endtask

   // Cross switch to clock 2: select flips at once, ack arrives SETTLE+1 cycles after acceptance
   task automatic test_switch();
      req_valid = 1'b1; req_sel = 1'b1;
      applyStimulus(1'b0);
      req_valid = 1'b0;
      checks++; if (dutReadyPre !== 1'b1) begin errors++; $display("[TB] FAIL sw_ready: got %b want 1", dutReadyPre); end
      checks++; if ({selection, busy} !== 2'b11) begin errors++; $display("[TB] FAIL sw_start: got sel/busy %b want 11", {selection, busy}); end
      for (int k = 2; k <= SETTLE + 1; k++) begin
         applyStimulus(1'b0);
         if (k <= SETTLE) begin
            checks++; if ({busy, req_ack} !== 2'b10) begin errors++; $display("[TB] FAIL sw_settle k=%0d: got busy/ack %b want 10", k, {busy, req_ack}); end
         end else begin
            checks++; if ({busy, req_ack, selection} !== 3'b011) begin errors++; $display("[TB] FAIL sw_done: got busy/ack/sel %b want 011", {busy, req_ack, selection}); end
         end
      end
      applyStimulus(1'b0);
      checks++; if (req_ack !== 1'b0) begin errors++; $display("[TB] FAIL sw_ack_width: got %b want 0", req_ack); end
   endtask

   // Request for the source already active: immediate ack, no switch
   task automatic test_same_source();
      req_valid = 1'b1; req_sel = selection;
      applyStimulus(1'b0);
      req_valid = 1'b0;
      checks++; if ({req_ack, busy, selection} !== {1'b1, 1'b0, mSel}) begin errors++; $display("[TB] FAIL same_src: got ack/busy/sel %b want %b", {req_ack, busy, selection}, {1'b1, 1'b0, mSel}); end
   endtask

   // Switch back to clock 1 and wait for completion under a cycle budget
   task automatic test_back_to_back();
      bit done;
      done = 1'b0;
      req_valid = 1'b1; req_sel = 1'b0;
      applyStimulus(1'b0);
      req_valid = 1'b0;
      for (int k = 0; k < SETTLE + 10 && !done; k++) begin
         applyStimulus(1'b0);
         checks++; if (req_ack !== mAck) begin errors++; $display("[TB] FAIL b2b_ack cyc=%0d: got %b want %b", cyc, req_ack, mAck); end
         if (!busy) done = 1'b1;
      end
      checks++; if (!done || selection !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done: got done=%0d sel=%b want done=1 sel=0", done, selection); end
   endtask

   // A request to a dead clock is rejected once, and the select line stays put
   task automatic test_dead_clock();
      auto2 = 1'b0;
      for (int k = 0; k < WDOG + 6; k++) applyStimulus(1'b0);
      checks++; if (clk2_ok !== 1'b0) begin errors++; $display("[TB] FAIL dead_ok2: got %b want 0", clk2_ok); end
      req_valid = 1'b1; req_sel = 1'b1;
      applyStimulus(1'b0);
      req_valid = 1'b0;
      checks++; if ({req_err, req_ack, selection, busy} !== 4'b1000) begin errors++; $display("[TB] FAIL dead_err: got err/ack/sel/busy %b want 1000", {req_err, req_ack, selection, busy}); end
      applyStimulus(1'b0);
      checks++; if ({req_err, selection} !== 2'b00) begin errors++; $display("[TB] FAIL dead_err_once: got err/sel %b want 00", {req_err, selection}); end
   endtask

   // Clock 2 dies while it is active. The macro decides whether the
   // controller fails over. A request that arrives in the failover cycle
   // must lose.
   task automatic test_failover();
      int  foSeen;
      bit  foPred;
      foSeen = 0;
      auto2 = 1'b1;
      for (int k = 0; k < 12; k++) applyStimulus(1'b0);
      req_valid = 1'b1; req_sel = 1'b1;
      applyStimulus(1'b0);
      req_valid = 1'b0;
      for (int k = 0; k < SETTLE + 2; k++) applyStimulus(1'b0);
      checks++; if ({selection, busy} !== 2'b10) begin errors++; $display("[TB] FAIL fo_on2: got sel/busy %b want 10", {selection, busy}); end
      auto2 = 1'b0;
      for (int k = 0; k < WDOG + 40; k++) begin
         foPred = FO_EN && !mBusy && !(mSel ? mOk2 : mOk1) && (mSel ? mOk1 : mOk2);
         req_valid = foPred; req_sel = 1'b0;
         applyStimulus(1'b0);
         req_valid = 1'b0;
         if (failover === 1'b1) foSeen++;
         checks++; if ({failover, req_ack, req_err} !== {mFo, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL fo_pulses cyc=%0d: got fo/ack/err %b want %b", cyc, {failover, req_ack, req_err}, {mFo, 2'b00}); end
         if (foPred) begin
            checks++; if ({dutReadyPre, selection, busy} !== 3'b001) begin errors++; $display("[TB] FAIL fo_priority: got ready/sel/busy %b want 001", {dutReadyPre, selection, busy}); end
         end
      end
      checks++; if (foSeen !== (FO_EN ? 1 : 0)) begin errors++; $display("[TB] FAIL fo_count: got %0d want %0d", foSeen, FO_EN ? 1 : 0); end
      checks++; if ({selection, busy} !== {!FO_EN, 1'b0}) begin errors++; $display("[TB] FAIL fo_final: got sel/busy %b want %b", {selection, busy}, {!FO_EN, 1'b0}); end
   endtask

   // Reset in the middle of a switch aborts it with no ack
   task automatic test_reset_mid_switch();
      applyStimulus(1'b1);
      auto1 = 1'b1; auto2 = 1'b1;
      for (int k = 0; k < 12; k++) applyStimulus(1'b0);
      req_valid = 1'b1; req_sel = 1'b1;
      applyStimulus(1'b0);
      req_valid = 1'b0;
      for (int k = 0; k < 5; k++) applyStimulus(1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rms_busy: got %b want 1", busy); end
      applyStimulus(1'b1);
      checks++; if ({selection, busy, req_ack} !== 3'b000) begin errors++; $display("[TB] FAIL rms_abort: got sel/busy/ack %b want 000", {selection, busy, req_ack}); end
      for (int k = 0; k < SETTLE + 4; k++) begin
         applyStimulus(1'b0);
         checks++; if ({req_ack, busy} !== 2'b00) begin errors++; $display("[TB] FAIL rms_quiet cyc=%0d: got ack/busy %b want 00", cyc, {req_ack, busy}); end
      end
   endtask

   // Random requests, heartbeat patterns and occasional resets, checked against the model
   task automatic test_random();
      bit rst;
      for (int k = 0; k < 1500; k++) begin
         if ((k % 64) == 0) begin
            auto1 = ($urandom_range(0, 3) != 0);
            auto2 = ($urandom_range(0, 3) != 0);
            per1 = $urandom_range(2, 24); per2 = $urandom_range(2, 24);
            ph1 = 0; ph2 = 0;
         end
         req_valid = ($urandom_range(0, 3) == 0);
         req_sel   = $urandom_range(0, 1);
         rst       = ($urandom_range(0, 299) == 0);
         applyStimulus(rst);
         req_valid = 1'b0;
         checks++; if (dutReadyPre !== mReadyPre) begin errors++; $display("[TB] FAIL rnd_ready cyc=%0d: got %b want %b", cyc, dutReadyPre, mReadyPre); end
         checks++; if ({selection, busy} !== {mSel, mBusy}) begin errors++; $display("[TB] FAIL rnd_state cyc=%0d: got sel/busy %b want %b", cyc, {selection, busy}, {mSel, mBusy}); end
         checks++; if ({req_ack, req_err, failover} !== {mAck, mErr, mFo}) begin errors++; $display("[TB] FAIL rnd_pulses cyc=%0d: got ack/err/fo %b want %b", cyc, {req_ack, req_err, failover}, {mAck, mErr, mFo}); end
         checks++; if ({clk1_ok, clk2_ok} !== {mOk1, mOk2}) begin errors++; $display("[TB] FAIL rnd_ok cyc=%0d: got %b want %b", cyc, {clk1_ok, clk2_ok}, {mOk1, mOk2}); end
      end
   endtask

   initial begin
      test_reset();
      test_heartbeat();
      test_switch();
      test_same_source();
      test_back_to_back();
      test_dead_clock();
      test_failover();
      test_reset_mid_switch();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
